// File: rtl/render_frame_scheduler.sv
// render_frame_scheduler
//
// Per-frame sequencer between game logic and the renderer. A frame tick arms
// one render cycle. Game state is copied into shadow registers in LATCH so the
// picture cannot tear while it is drawn. The draw enable is held until the
// renderer reports done, or until the render times out. The enable is then
// dropped for one cycle, and a single advance strobe steps game logic.
//
// Optional build macro: RENDER_VSYNC_ALIGN_EN
//   defined   : tick is the synchronised rising edge of vsync. The edge passes
//               through two sync flops and one edge register, so tick arrives
//               3 cycles after the edge. There is no internal frame counter,
//               and FRAME_CYCLES is ignored.
//   undefined : tick comes from the internal frame counter and vsync is unused.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   enable       in   game running; low returns the sequencer to IDLE
//   keys_in      in   [19:0] live key vector
//   yoffset_in   in   [8:0]  live bottom-key y offset
//   num_hit_in   in   [1:0]  live hit count
//   score_in     in   [9:0]  live score
//   render_done  in   renderer completion level
//   vsync        in   external frame strobe (vsync-aligned build only)
//   draw_en      out  registered renderer enable
//   keys/yoffset/num_hit/score  out  snapshots taken in LATCH
//   plot         out  draw_en & ~render_done
//   frame_start  out  one-cycle pulse in LATCH
//   advance      out  one-cycle pulse in ADVANCE
//   busy         out  high in LATCH, DRAW and RELEASE
//   drop_count   out  [7:0] ticks missed while busy, saturating
//   timeout_err  out  sticky render-timeout flag
module render_frame_scheduler #(
  parameter int FRAME_CYCLES   = 833333,
  parameter int TIMEOUT_CYCLES = 400000,
  parameter int CNT_W          = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [19:0] keys_in,
  input  logic [8:0]  yoffset_in,
  input  logic [1:0]  num_hit_in,
  input  logic [9:0]  score_in,
  input  logic        render_done,
  input  logic        vsync,
  output logic        draw_en,
  output logic [19:0] keys,
  output logic [8:0]  yoffset,
  output logic [1:0]  num_hit,
  output logic [9:0]  score,
  output logic        plot,
  output logic        frame_start,
  output logic        advance,
  output logic        busy,
  output logic [7:0]  drop_count,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_LATCH   = 3'd2,
    ST_DRAW    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_ADVANCE = 3'd5
  } state_t;

  state_t           state_r;
  logic             tick_s;
  logic             timeout_hit_s;
  logic [CNT_W-1:0] timeout_cnt_r;
  logic             draw_en_r;
  logic             frame_start_r;
  logic             advance_r;
  logic             busy_r;
  logic             timeout_err_r;
  logic [7:0]       drop_count_r;
  logic [19:0]      keys_r;
  logic [8:0]       yoffset_r;
  logic [1:0]       num_hit_r;
  logic [9:0]       score_r;

`ifdef RENDER_VSYNC_ALIGN_EN
  logic [2:0] vsync_sync_r;
  logic       vsync_edge_r;

  // Two-flop synchroniser, history flop and registered rising-edge detect on vsync
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_sync_r <= 3'b000;
      vsync_edge_r <= 1'b0;
    end else begin
      vsync_sync_r <= {vsync_sync_r[1:0], vsync};
      vsync_edge_r <= vsync_sync_r[1] & ~vsync_sync_r[2];
    end
  end

  assign tick_s = enable & vsync_edge_r;
`else
  logic [CNT_W-1:0] frame_cnt_r;
  logic             unused_vsync_s;

  assign unused_vsync_s = vsync;

  // Free-running frame period counter, parked at zero while the game is stopped
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_r <= {CNT_W{1'b0}};
    end else if (!enable) begin
      frame_cnt_r <= {CNT_W{1'b0}};
    end else if (frame_cnt_r == CNT_W'(FRAME_CYCLES - 1)) begin
      frame_cnt_r <= {CNT_W{1'b0}};
    end else begin
      frame_cnt_r <= frame_cnt_r + CNT_W'(1);
    end
  end

  assign tick_s = enable & (frame_cnt_r == CNT_W'(FRAME_CYCLES - 1));
`endif

  assign timeout_hit_s = (timeout_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Frame sequencer: state transitions together with the registered strobes,
  // draw enable, busy flag and render timeout tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      draw_en_r     <= 1'b0;
      frame_start_r <= 1'b0;
      advance_r     <= 1'b0;
      busy_r        <= 1'b0;
      timeout_cnt_r <= {CNT_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else if (!enable) begin
      // Abandon the frame quietly: no advance, sticky status kept
      state_r       <= ST_IDLE;
      draw_en_r     <= 1'b0;
      frame_start_r <= 1'b0;
      advance_r     <= 1'b0;
      busy_r        <= 1'b0;
      timeout_cnt_r <= {CNT_W{1'b0}};
    end else begin
      frame_start_r <= 1'b0;
      advance_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          state_r   <= ST_ARM;
          draw_en_r <= 1'b0;
          busy_r    <= 1'b0;
        end
        ST_ARM: begin
          if (tick_s) begin
            state_r       <= ST_LATCH;
            frame_start_r <= 1'b1;
            busy_r        <= 1'b1;
          end else begin
            state_r <= ST_ARM;
          end
        end
        ST_LATCH: begin
          state_r       <= ST_DRAW;
          draw_en_r     <= 1'b1;
          busy_r        <= 1'b1;
          timeout_cnt_r <= {CNT_W{1'b0}};
        end
        ST_DRAW: begin
          // A done arriving in the final timeout cycle still counts as success
          if (render_done) begin
            state_r   <= ST_RELEASE;
            draw_en_r <= 1'b0;
          end else if (timeout_hit_s) begin
            state_r       <= ST_RELEASE;
            draw_en_r     <= 1'b0;
            timeout_err_r <= 1'b1;
          end else begin
            timeout_cnt_r <= timeout_cnt_r + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          state_r   <= ST_ADVANCE;
          advance_r <= 1'b1;
          busy_r    <= 1'b0;
        end
        ST_ADVANCE: begin
          state_r <= ST_ARM;
        end
        default: begin
          state_r   <= ST_IDLE;
          draw_en_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Shadow copy of game state, refreshed only while in LATCH
  always_ff @(posedge clk) begin
    if (reset) begin
      keys_r    <= 20'h00000;
      yoffset_r <= 9'h000;
      num_hit_r <= 2'b00;
      score_r   <= 10'h000;
    end else if (enable && (state_r == ST_LATCH)) begin
      keys_r    <= keys_in;
      yoffset_r <= yoffset_in;
      num_hit_r <= num_hit_in;
      score_r   <= score_in;
    end
  end

  // Count ticks that arrive when the sequencer is not waiting for one
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_r <= 8'h00;
    end else if (tick_s && (state_r != ST_ARM) && (drop_count_r != 8'hFF)) begin
      drop_count_r <= drop_count_r + 8'h01;
    end
  end

  assign draw_en     = draw_en_r;
  assign plot        = draw_en_r & ~render_done;
  assign frame_start = frame_start_r;
  assign advance     = advance_r;
  assign busy        = busy_r;
  assign drop_count  = drop_count_r;
  assign timeout_err = timeout_err_r;
  assign keys        = keys_r;
  assign yoffset     = yoffset_r;
  assign num_hit     = num_hit_r;
  assign score       = score_r;

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Scoreboard bench for render_frame_scheduler (FRAME_CYCLES=100, TIMEOUT_CYCLES=150).
// The stimulus plans each frame from the tick schedule and a chosen render
// latency. It pushes the expected frame_start, draw window and advance events
// into queues. A negedge monitor pops those queues and compares whenever the DUT
// shows an event.
module tb_render_frame_scheduler;
  localparam int FC = 100;
  localparam int TC = 150;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [19:0] keys_in = 20'h0;
  logic [8:0]  yoffset_in = 9'h0;
  logic [1:0]  num_hit_in = 2'h0;
  logic [9:0]  score_in = 10'h0;
  logic        render_done = 1'b0;
  logic        vsync = 1'b0;
  logic        draw_en, plot, frame_start, advance, busy, timeout_err;
  logic [19:0] keys;
  logic [8:0]  yoffset;
  logic [1:0]  num_hit;
  logic [9:0]  score;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  render_frame_scheduler #(.FRAME_CYCLES(FC), .TIMEOUT_CYCLES(TC), .CNT_W(20)) dut (
    .clk(clk), .reset(reset), .enable(enable), .keys_in(keys_in),
    .yoffset_in(yoffset_in), .num_hit_in(num_hit_in), .score_in(score_in),
    .render_done(render_done), .vsync(vsync), .draw_en(draw_en), .keys(keys),
    .yoffset(yoffset), .num_hit(num_hit), .score(score), .plot(plot),
    .frame_start(frame_start), .advance(advance), .busy(busy),
    .drop_count(drop_count), .timeout_err(timeout_err)
  );

  typedef struct { int c; logic [19:0] k; logic [8:0] y; logic [1:0] n; logic [9:0] s; int d; } fs_t;
  typedef struct { int c; logic te; } adv_t;
  typedef struct { int rise; int fall; } win_t;

  fs_t  fs_q[$];
  adv_t adv_q[$];
  win_t win_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // Model state: next tick cycle, drops so far, sticky timeout, last draw end
  int T = 0;
  int drops = 0;
  bit to = 1'b0;
  int last_fin = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected at cycle %0d", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    keys_in     = 20'($urandom);
    yoffset_in  = 9'($urandom);
    num_hit_in  = 2'($urandom);
    score_in    = 10'($urandom);
    render_done = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  // One frame from the model's point of view. L is the render latency in
  // DRAW cycles, and L >= TC means the renderer never answers. When push_adv
  // is clear the frame is cut short by the caller, so no window or advance is queued.
  task automatic do_frame(input int L, input bit push_adv);
    int dstart, fin, n;
    fs_t e; win_t w; adv_t a;
    run_to(T + 1);
    e.c = T + 1; e.k = keys_in; e.y = yoffset_in; e.n = num_hit_in; e.s = score_in; e.d = drops;
    fs_q.push_back(e);
    dstart = T + 2;
    if (!push_adv) return;
    if (L <= TC - 1) fin = dstart + L;
    else begin
      fin = dstart + TC - 1;
      to = 1'b1;
    end
    w.rise = dstart; w.fall = fin + 1; win_q.push_back(w);
    a.c = fin + 2; a.te = to; adv_q.push_back(a);
    n = 0;
    for (int t = T + FC; t <= fin + 2; t += FC) n++;
    drops = (drops + n > 255) ? 255 : drops + n;
    if (L <= TC - 1) begin
      run_to(dstart + L);
      render_done = 1'b1;
    end
    T = T + FC * (n + 1);
    last_fin = fin;
  endtask

  // Monitor: pop expectations whenever the DUT presents an event
  fs_t  m_fs, snap_exp, last_snap;
  adv_t m_adv;
  win_t m_win;
  bit   snap_pend = 1'b0;
  logic prev_draw = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (snap_pend) begin
        snap_pend = 1'b0;
        check("snap_keys", keys, snap_exp.k);
        check("snap_yoffset", yoffset, snap_exp.y);
        check("snap_num_hit", num_hit, snap_exp.n);
        check("snap_score", score, snap_exp.s);
        check("busy_in_draw", busy, 1);
        check("plot_in_draw", plot, render_done ? 0 : 1);
        last_snap = snap_exp;
      end
      if (frame_start) begin
        if (fs_q.size() == 0) unexpected("frame_start");
        else begin
          m_fs = fs_q.pop_front();
          check("frame_start_cycle", cyc, m_fs.c);
          check("drop_count", drop_count, m_fs.d);
          snap_exp = m_fs;
          snap_pend = 1'b1;
        end
      end
      if (draw_en && !prev_draw) begin
        if (win_q.size() == 0) unexpected("draw_en_rise");
        else check("draw_en_rise", cyc, win_q[0].rise);
      end
      if (!draw_en && prev_draw) begin
        if (win_q.size() == 0) unexpected("draw_en_fall");
        else begin
          m_win = win_q.pop_front();
          check("draw_en_fall", cyc, m_win.fall);
          check("plot_after_draw", plot, 0);
        end
      end
      if (advance) begin
        if (adv_q.size() == 0) unexpected("advance");
        else begin
          m_adv = adv_q.pop_front();
          check("advance_cycle", cyc, m_adv.c);
          check("timeout_err", timeout_err, m_adv.te);
          check("busy_at_advance", busy, 0);
          check("score_stable", score, last_snap.s);
          check("keys_stable", keys, last_snap.k);
        end
      end
      prev_draw = draw_en;
    end
  end

  initial begin
    int Y;
    win_t w;
    keys_in = 20'h12481;
    score_in = 10'd37;
    repeat (3) @(posedge clk);
    #1;
    check("rst_draw_en", draw_en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_advance", advance, 0);
    check("rst_keys", keys, 0);
    check("rst_score", score, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    enable = 1'b1;
    cyc = 0;
    mon_en = 1'b1;
    T = FC - 1;

    // Directed first frames (boundaries), then random render latencies
    for (int f = 0; f < 22; f++) begin
      case (f)
        0: do_frame(19, 1'b1);
        1: do_frame(200, 1'b1);
        2: do_frame(TC - 1, 1'b1);
        3: do_frame(TC - 2, 1'b1);
        4: do_frame(0, 1'b1);
        5: do_frame(FC - 2, 1'b1);
        6: do_frame(TC, 1'b1);
        default: do_frame($urandom_range(0, 179), 1'b1);
      endcase
    end

    // enable drops 10 cycles into DRAW: draw_en falls next cycle, no advance
    do_frame(0, 1'b0);
    w.rise = T + 2; w.fall = T + 13; win_q.push_back(w);
    run_to(T + 12);
    enable = 1'b0;
    run_to(T + 60);
    enable = 1'b1;
    T = T + 60 + FC - 1;
    do_frame(30, 1'b1);

    // Reset in the middle of DRAW clears everything, including sticky status
    do_frame(0, 1'b0);
    Y = T + 22;
    w.rise = T + 2; w.fall = Y + 1; win_q.push_back(w);
    run_to(Y);
    check("pre_reset_drop_count", drop_count, drops);
    check("pre_reset_timeout_err", timeout_err, to);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_draw_en", draw_en, 0);
    check("mid_rst_plot", plot, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_start", frame_start, 0);
    check("mid_rst_advance", advance, 0);
    check("mid_rst_keys", keys, 0);
    check("mid_rst_yoffset", yoffset, 0);
    check("mid_rst_num_hit", num_hit, 0);
    check("mid_rst_score", score, 0);
    check("mid_rst_drop_count", drop_count, 0);
    check("mid_rst_timeout_err", timeout_err, 0);
    drops = 0;
    to = 1'b0;
    T = Y + 1 + FC - 1;
    do_frame(TC + 5, 1'b1);
    do_frame($urandom_range(0, 120), 1'b1);

    run_to(last_fin + 10);
    check("final_drop_count", drop_count, drops);
    check("final_timeout_err", timeout_err, to);
    check("fs_q_left", fs_q.size(), 0);
    check("adv_q_left", adv_q.size(), 0);
    check("win_q_left", win_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
